// File: rtl/rf_wb_if.sv
// Write-back bus for rf_wb_queue: ALU/load request ports, RF write port and decode forwarding.
// Handshake: a request transfers on a clock edge where valid && ready; ready never depends on the request's own reg/data.
interface rf_wb_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_reg;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_reg;
    logic [DW-1:0] mem_data;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          fwd_rs_hit;
    logic [DW-1:0] fwd_rs;
    logic          fwd_rt_hit;
    logic [DW-1:0] fwd_rt;

    modport master (
        output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, rs, rt,
        input  alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata,
               fwd_rs_hit, fwd_rs, fwd_rt_hit, fwd_rt
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, rs, rt,
        output alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata,
               fwd_rs_hit, fwd_rs, fwd_rt_hit, fwd_rt
    );
endinterface

// File: rtl/rf_wb_queue.sv
// Register-file write-back queue: buffers ALU/load results, retires one per cycle, forwards queued values.
// Optional WB_STATS_EN adds write and stall counters.
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic       clk,
    input  logic       rst,
    rf_wb_if.slave     bus
`ifdef WB_STATS_EN
    ,
    output logic [31:0] wb_wr_cnt,
    output logic [31:0] wb_stall_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] reg_q  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic enq_alu;
    logic enq_mem;
    logic pop;

    // Readiness looks only at registered count; a same-cycle pop never frees space.
    assign bus.alu_ready = (count <= CW'(DEPTH - 1));
    assign bus.mem_ready = bus.alu_valid ? (count <= CW'(DEPTH - 2))
                                         : (count <= CW'(DEPTH - 1));

    // Register 0 requests handshake normally but are dropped.
    assign enq_alu = bus.alu_valid && bus.alu_ready && (bus.alu_reg != '0);
    assign enq_mem = bus.mem_valid && bus.mem_ready && (bus.mem_reg != '0);
    assign pop     = (count != '0);

    assign bus.rf_we    = pop;
    assign bus.rf_waddr = reg_q[head];
    assign bus.rf_wdata = data_q[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_alu) begin
                reg_q[tail]  <= bus.alu_reg;
                data_q[tail] <= bus.alu_data;
            end
            // The ALU entry takes the older slot when both ports enqueue.
            if (enq_mem) begin
                reg_q[tail + PW'(enq_alu)]  <= bus.mem_reg;
                data_q[tail + PW'(enq_alu)] <= bus.mem_data;
            end
            tail  <= tail + PW'(enq_alu) + PW'(enq_mem);
            head  <= head + PW'(pop);
            count <= count + CW'(enq_alu) + CW'(enq_mem) - CW'(pop);
        end
    end

    logic [PW-1:0] idx;

    // Walk from oldest to youngest so the last match (youngest) wins.
    always_comb begin
        bus.fwd_rs_hit = 1'b0;
        bus.fwd_rs     = '0;
        bus.fwd_rt_hit = 1'b0;
        bus.fwd_rt     = '0;
        idx            = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count) begin
                if ((bus.rs != '0) && (reg_q[idx] == bus.rs)) begin
                    bus.fwd_rs_hit = 1'b1;
                    bus.fwd_rs     = data_q[idx];
                end
                if ((bus.rt != '0) && (reg_q[idx] == bus.rt)) begin
                    bus.fwd_rt_hit = 1'b1;
                    bus.fwd_rt     = data_q[idx];
                end
            end
        end
    end

`ifdef WB_STATS_EN
    logic stall;
    assign stall = (bus.alu_valid && !bus.alu_ready) || (bus.mem_valid && !bus.mem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wr_cnt    <= '0;
            wb_stall_cnt <= '0;
        end else begin
            wb_wr_cnt    <= wb_wr_cnt + 32'(bus.rf_we);
            wb_stall_cnt <= wb_stall_cnt + 32'(stall);
        end
    end
`endif
endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed and random bench for rf_wb_queue: ready/count model, write-order scoreboard, forwarding checks.
// Define WB_STATS_EN to also check the statistics counters.
module tb_rf_wb_queue;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk;
    logic rst;

    rf_wb_if #(.AW(AW), .DW(DW)) bus ();

`ifdef WB_STATS_EN
    logic [31:0] wb_wr_cnt;
    logic [31:0] wb_stall_cnt;
`endif

    rf_wb_queue #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef WB_STATS_EN
        ,
        .wb_wr_cnt    (wb_wr_cnt),
        .wb_stall_cnt (wb_stall_cnt)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;
    int m_count = 0;
    logic [AW+DW-1:0] exp_q[$];
    int exp_wr = 0;
    int exp_stall = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every RF write must match the oldest accepted request
    always @(negedge clk) begin
        if (!rst && bus.rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rf_write", {27'd0, bus.rf_waddr, bus.rf_wdata}, 64'd0);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                check("rf_write", {27'd0, bus.rf_waddr, bus.rf_wdata}, {27'd0, e});
            end
        end
    end

    // reference counts for the statistics outputs
    always @(negedge clk) begin
        if (rst) begin
            exp_wr    = 0;
            exp_stall = 0;
        end else begin
            if (bus.rf_we === 1'b1) exp_wr++;
            if ((bus.alu_valid && !bus.alu_ready) || (bus.mem_valid && !bus.mem_ready)) exp_stall++;
        end
    end

    // driver: one cycle of stimulus with ready/count checks against the model
    task automatic cycle(input logic av, input logic [AW-1:0] a_reg, input logic [DW-1:0] a_data,
                         input logic mv, input logic [AW-1:0] m_reg, input logic [DW-1:0] m_data);
        logic exp_ar;
        logic exp_mr;
        int   enq;
        bus.alu_valid = av;
        bus.alu_reg   = a_reg;
        bus.alu_data  = a_data;
        bus.mem_valid = mv;
        bus.mem_reg   = m_reg;
        bus.mem_data  = m_data;
        @(negedge clk);
        exp_ar = (m_count <= 3);
        exp_mr = av ? (m_count <= 2) : (m_count <= 3);
        check("alu_ready", 64'(bus.alu_ready), 64'(exp_ar));
        check("mem_ready", 64'(bus.mem_ready), 64'(exp_mr));
        check("rf_we", 64'(bus.rf_we), 64'(m_count != 0));
        check("count", 64'(dut.count), 64'(m_count));
        enq = 0;
        if (av && exp_ar && a_reg != 0) begin
            exp_q.push_back({a_reg, a_data});
            enq++;
        end
        if (mv && exp_mr && m_reg != 0) begin
            exp_q.push_back({m_reg, m_data});
            enq++;
        end
        @(posedge clk);
        m_count = m_count + enq - ((m_count != 0) ? 1 : 0);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_count = 0;
    endtask

    task automatic fwd_check(input string tag, input logic [AW-1:0] rs_v, input logic [AW-1:0] rt_v,
                             input logic rs_hit, input logic [DW-1:0] rs_val,
                             input logic rt_hit, input logic [DW-1:0] rt_val);
        bus.rs = rs_v;
        bus.rt = rt_v;
        #1;
        check({tag, "_rs_hit"}, 64'(bus.fwd_rs_hit), 64'(rs_hit));
        check({tag, "_rs"}, 64'(bus.fwd_rs), 64'(rs_val));
        check({tag, "_rt_hit"}, 64'(bus.fwd_rt_hit), 64'(rt_hit));
        check({tag, "_rt"}, 64'(bus.fwd_rt), 64'(rt_val));
    endtask

    initial begin
        rst = 1'b1;
        bus.alu_valid = 1'b0;
        bus.alu_reg   = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_reg   = '0;
        bus.mem_data  = '0;
        bus.rs        = '0;
        bus.rt        = '0;
        repeat (2) @(posedge clk);
        #1;
        // reset state
        check("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("rst_mem_ready", 64'(bus.mem_ready), 64'd1);
        check("rst_rf_we", 64'(bus.rf_we), 64'd0);
        check("rst_rs_hit", 64'(bus.fwd_rs_hit), 64'd0);
        check("rst_rt_hit", 64'(bus.fwd_rt_hit), 64'd0);
        rst = 1'b0;

        // single request, written the following cycle then empty
        cycle(1'b1, 5'd3, 32'hA5, 1'b0, '0, '0);
        idle(2);

        // dual accept to the same register; youngest forwards
        cycle(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
        fwd_check("dual2", 5'd5, 5'd7, 1'b1, 32'h22, 1'b0, 32'h0);
        idle(1);
        fwd_check("dual1", 5'd5, 5'd5, 1'b1, 32'h22, 1'b1, 32'h22);
        idle(2);
        fwd_check("dual0", 5'd5, 5'd5, 1'b0, 32'h0, 1'b0, 32'h0);

        // fill: mem_ready drops at count 3 while alu_valid is held
        cycle(1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h101);
        cycle(1'b1, 5'd12, 32'h102, 1'b1, 5'd13, 32'h103);
        fwd_check("fill", 5'd12, 5'd11, 1'b1, 32'h102, 1'b1, 32'h101);
        cycle(1'b1, 5'd14, 32'h104, 1'b1, 5'd15, 32'h105);
        cycle(1'b1, 5'd16, 32'h106, 1'b1, 5'd17, 32'h107);
        cycle(1'b0, '0, '0, 1'b1, 5'd18, 32'h108);
        idle(5);

        // register 0 completes the handshake but is never queued
        cycle(1'b1, 5'd0, 32'hFF, 1'b0, '0, '0);
        fwd_check("reg0", 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1);

        // reset with three entries queued
        cycle(1'b1, 5'd20, 32'h200, 1'b1, 5'd21, 32'h201);
        cycle(1'b1, 5'd22, 32'h202, 1'b1, 5'd23, 32'h203);
        check("pre_reset_count", 64'(dut.count), 64'd3);
        do_reset();
        idle(2);
        fwd_check("post_reset", 5'd22, 5'd23, 1'b0, 32'h0, 1'b0, 32'h0);

        // random traffic with collisions and register 0
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom);
        end
        idle(6);
        check("drained", 64'(exp_q.size()), 64'd0);

`ifdef WB_STATS_EN
        check("wb_wr_cnt", 64'(wb_wr_cnt), 64'(exp_wr));
        check("wb_stall_cnt", 64'(wb_stall_cnt), 64'(exp_stall));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
